// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad combination-lock controller driving a hex display.
// Collects four hex digits, programs or checks the passcode, and enforces a timed lockout.
module lock_sequencer #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 100000000,
  parameter int CNT_W          = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       enter_btn,
  input  logic       lock_btn,
  input  logic       clear_btn,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] hex4,
  output logic [2:0] digit_count,
  output logic       enter,
  output logic       lock,
  output logic       unlock,
  output logic       is_locked,
  output logic       alarm,
  output logic [2:0] fail_count
);
  typedef enum logic [1:0] {INIT, LOCKED, UNLOCKED, LOCKOUT} state_t;
  state_t           state;
  logic [15:0]      code;
  logic [CNT_W-1:0] cnt;
  logic             started;
  logic [15:0]      entry;
  logic             full;
  assign entry = {hex1, hex2, hex3, hex4};
  assign full  = digit_count == 3'd4;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      code        <= '0;
      cnt         <= '0;
      started     <= 1'b0;
      hex1        <= '0;
      hex2        <= '0;
      hex3        <= '0;
      hex4        <= '0;
      digit_count <= '0;
      enter       <= 1'b0;
      lock        <= 1'b0;
      unlock      <= 1'b0;
      is_locked   <= 1'b0;
      alarm       <= 1'b0;
      fail_count  <= '0;
    end else begin
      // The first clock after reset release announces the initial display state.
      enter   <= !started;
      lock    <= 1'b0;
      unlock  <= 1'b0;
      started <= 1'b1;
      if (state == LOCKOUT) begin
        if (cnt == '0) begin
          state      <= LOCKED;
          alarm      <= 1'b0;
          fail_count <= '0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else if (clear_btn) begin
        {hex1, hex2, hex3, hex4} <= '0;
        digit_count <= '0;
        if (state == UNLOCKED) begin
          state <= INIT;
          enter <= 1'b1;
        end
      end else if (enter_btn) begin
        if (full) begin
          {hex1, hex2, hex3, hex4} <= '0;
          digit_count <= '0;
          if (state != LOCKED) begin
            code       <= entry;
            lock       <= 1'b1;
            state      <= LOCKED;
            is_locked  <= 1'b1;
            fail_count <= '0;
          end else if (entry == code) begin
            unlock     <= 1'b1;
            state      <= UNLOCKED;
            is_locked  <= 1'b0;
            fail_count <= '0;
          end else begin
            fail_count <= fail_count + 3'd1;
            if (fail_count + 3'd1 == 3'(MAX_FAILS)) begin
              state <= LOCKOUT;
              cnt   <= CNT_W'(LOCKOUT_CYCLES - 1);
              alarm <= 1'b1;
            end
          end
        end
      end else if (lock_btn) begin
        if (state == UNLOCKED) begin
          lock      <= 1'b1;
          state     <= LOCKED;
          is_locked <= 1'b1;
        end
      end else if (key_valid && !full) begin
        hex1        <= digit_count == 3'd0 ? key_code : hex1;
        hex2        <= digit_count == 3'd1 ? key_code : hex2;
        hex3        <= digit_count == 3'd2 ? key_code : hex3;
        hex4        <= digit_count == 3'd3 ? key_code : hex4;
        digit_count <= digit_count + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed scenarios plus random stimulus against a behavioural lock model.
module tb_lock_sequencer;
  localparam int MAXF = 3;
  localparam int LOCK_CYC = 20;
  logic clock = 0;
  logic reset = 0;
  logic key_valid = 0, enter_btn = 0, lock_btn = 0, clear_btn = 0;
  logic [3:0] key_code = 0;
  logic [3:0] hex1, hex2, hex3, hex4;
  logic [2:0] digit_count, fail_count;
  logic enter, lock, unlock, is_locked, alarm;
  int n_checks = 0, n_fail = 0;

  lock_sequencer #(.MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK_CYC), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .enter_btn(enter_btn), .lock_btn(lock_btn), .clear_btn(clear_btn),
    .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .digit_count(digit_count),
    .enter(enter), .lock(lock), .unlock(unlock), .is_locked(is_locked),
    .alarm(alarm), .fail_count(fail_count));

  always #5 clock = ~clock;

  logic [26:0] dut_vec;
  assign dut_vec = {hex1, hex2, hex3, hex4, digit_count, enter, lock, unlock, is_locked, alarm, fail_count};

  // Behavioural model: digit list, stored code, mode name, failure tally, lockout time left.
  logic [3:0] m_q[$];
  logic [15:0] m_code;
  string m_mode;
  int m_fails, m_remain;
  bit m_first, m_enter, m_lock, m_unlock;

  function automatic void m_reset();
    m_q.delete(); m_code = 0; m_mode = "INIT"; m_fails = 0; m_remain = 0;
    m_first = 1; m_enter = 0; m_lock = 0; m_unlock = 0;
  endfunction

  function automatic void m_update(bit kv, logic [3:0] kc, bit eb, bit lb, bit cb);
    logic [15:0] val;
    m_enter = m_first; m_first = 0; m_lock = 0; m_unlock = 0;
    if (m_mode == "LOCKOUT") begin
      m_remain--;
      if (m_remain == 0) begin m_mode = "LOCKED"; m_fails = 0; end
    end else if (cb) begin
      m_q.delete();
      if (m_mode == "UNLOCKED") begin m_mode = "INIT"; m_enter = 1; end
    end else if (eb) begin
      if (m_q.size() == 4) begin
        val = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_q.delete();
        if (m_mode == "LOCKED") begin
          if (val == m_code) begin m_unlock = 1; m_mode = "UNLOCKED"; m_fails = 0; end
          else begin
            m_fails++;
            if (m_fails == MAXF) begin m_mode = "LOCKOUT"; m_remain = LOCK_CYC; end
          end
        end else begin
          m_code = val; m_lock = 1; m_mode = "LOCKED"; m_fails = 0;
        end
      end
    end else if (lb) begin
      if (m_mode == "UNLOCKED") begin m_lock = 1; m_mode = "LOCKED"; end
    end else if (kv && m_q.size() < 4) m_q.push_back(kc);
  endfunction

  function automatic logic [26:0] exp_vec();
    logic [3:0] h[4];
    for (int i = 0; i < 4; i++) h[i] = i < m_q.size() ? m_q[i] : 4'h0;
    return {h[0], h[1], h[2], h[3], 3'(m_q.size()), m_enter, m_lock, m_unlock,
            m_mode == "LOCKED" || m_mode == "LOCKOUT", m_mode == "LOCKOUT", 3'(m_fails)};
  endfunction

  task automatic step(input bit kv, input logic [3:0] kc, input bit eb, input bit lb, input bit cb);
    key_valid = kv; key_code = kc; enter_btn = eb; lock_btn = lb; clear_btn = cb;
    @(posedge clock);
    m_update(kv, kc, eb, lb, cb);
    #1;
    key_valid = 0; enter_btn = 0; lock_btn = 0; clear_btn = 0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) step(1, c[i*4 +: 4], 0, 0, 0);
    step(0, 0, 1, 0, 0);
  endtask

  task automatic test_reset();
    reset = 0; m_reset();
    #13;
    n_checks++;
    if (dut_vec !== 27'h0) begin n_fail++; $display("FAIL reset_state got=%h want=%h", dut_vec, 27'h0); end
    @(negedge clock); reset = 1;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (dut_vec !== exp_vec() || enter !== 1'b1) begin n_fail++; $display("FAIL reset_enter_pulse got=%h want=%h", dut_vec, exp_vec()); end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (enter !== 1'b0) begin n_fail++; $display("FAIL enter_pulse_width got=%b want=0", enter); end
  endtask

  task automatic test_program_lock();
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (dut_vec !== exp_vec() || is_locked !== 1'b0) begin n_fail++; $display("FAIL init_lock_ignored got=%h want=%h", dut_vec, exp_vec()); end
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 0, 0);
    n_checks++;
    if ({hex1, hex2, hex3, hex4, digit_count} !== {16'h1234, 3'd4}) begin n_fail++; $display("FAIL program_digits got=%h want=%h", {hex1, hex2, hex3, hex4, digit_count}, {16'h1234, 3'd4}); end
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (dut_vec !== exp_vec() || lock !== 1'b1 || is_locked !== 1'b1 || digit_count !== 3'd0) begin n_fail++; $display("FAIL program_lock got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_unlock();
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (dut_vec !== exp_vec() || lock !== 1'b0) begin n_fail++; $display("FAIL locked_lock_ignored got=%h want=%h", dut_vec, exp_vec()); end
    enter_code(16'h1234);
    n_checks++;
    if (dut_vec !== exp_vec() || unlock !== 1'b1 || is_locked !== 1'b0 || fail_count !== 3'd0) begin n_fail++; $display("FAIL correct_code got=%h want=%h", dut_vec, exp_vec()); end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (dut_vec !== exp_vec() || lock !== 1'b1 || is_locked !== 1'b1) begin n_fail++; $display("FAIL relock got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_boundaries();
    for (int i = 10; i <= 14; i++) step(1, 4'(i), 0, 0, 0);
    n_checks++;
    if ({hex1, hex2, hex3, hex4, digit_count} !== {16'hABCD, 3'd4} || dut_vec !== exp_vec()) begin n_fail++; $display("FAIL fifth_key_dropped got=%h want=%h", dut_vec, exp_vec()); end
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (dut_vec !== exp_vec() || digit_count !== 3'd0) begin n_fail++; $display("FAIL clear_buffer got=%h want=%h", dut_vec, exp_vec()); end
    for (int i = 1; i <= 3; i++) step(1, 4'(i), 0, 0, 0);
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (dut_vec !== exp_vec() || digit_count !== 3'd3 || {hex1, hex2, hex3} !== 12'h123 || fail_count !== 3'd0) begin n_fail++; $display("FAIL short_enter got=%h want=%h", dut_vec, exp_vec()); end
    step(1, 4, 0, 0, 0);
    step(1, 7, 1, 0, 0);
    n_checks++;
    if (dut_vec !== exp_vec() || unlock !== 1'b1 || digit_count !== 3'd0) begin n_fail++; $display("FAIL key_with_enter got=%h want=%h", dut_vec, exp_vec()); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_lockout();
    enter_code(16'h0000);
    n_checks++;
    if (dut_vec !== exp_vec() || fail_count !== 3'd1 || alarm !== 1'b0) begin n_fail++; $display("FAIL wrong_code_1 got=%h want=%h", dut_vec, exp_vec()); end
    enter_code(16'h0000);
    n_checks++;
    if (dut_vec !== exp_vec() || fail_count !== 3'd2) begin n_fail++; $display("FAIL wrong_code_2 got=%h want=%h", dut_vec, exp_vec()); end
    enter_code(16'h0000);
    n_checks++;
    if (dut_vec !== exp_vec() || alarm !== 1'b1 || is_locked !== 1'b1) begin n_fail++; $display("FAIL lockout_entry got=%h want=%h", dut_vec, exp_vec()); end
    for (int c = 1; c < LOCK_CYC; c++) begin
      step(1, 4'(c), c % 5 == 0, c % 7 == 0, c % 11 == 0);
      n_checks++;
      if (dut_vec !== exp_vec() || alarm !== 1'b1 || digit_count !== 3'd0) begin n_fail++; $display("FAIL lockout_hold c=%0d got=%h want=%h", c, dut_vec, exp_vec()); end
    end
    step(1, 1, 0, 0, 0);
    n_checks++;
    if (dut_vec !== exp_vec() || alarm !== 1'b0 || fail_count !== 3'd0 || is_locked !== 1'b1) begin n_fail++; $display("FAIL lockout_exit got=%h want=%h", dut_vec, exp_vec()); end
    enter_code(16'h1234);
    n_checks++;
    if (dut_vec !== exp_vec() || unlock !== 1'b1) begin n_fail++; $display("FAIL post_lockout_unlock got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_clear_reprogram();
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (dut_vec !== exp_vec() || enter !== 1'b1 || is_locked !== 1'b0) begin n_fail++; $display("FAIL clear_to_init got=%h want=%h", dut_vec, exp_vec()); end
    enter_code(16'h9876);
    n_checks++;
    if (dut_vec !== exp_vec() || lock !== 1'b1) begin n_fail++; $display("FAIL reprogram got=%h want=%h", dut_vec, exp_vec()); end
    enter_code(16'h1234);
    n_checks++;
    if (dut_vec !== exp_vec() || fail_count !== 3'd1 || unlock !== 1'b0) begin n_fail++; $display("FAIL old_code_fails got=%h want=%h", dut_vec, exp_vec()); end
    enter_code(16'h9876);
    n_checks++;
    if (dut_vec !== exp_vec() || unlock !== 1'b1 || fail_count !== 3'd0) begin n_fail++; $display("FAIL new_code_unlocks got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < MAXF; i++) enter_code(16'h5555);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (alarm !== 1'b1) begin n_fail++; $display("FAIL async_pre_alarm got=%b want=1", alarm); end
    #2 reset = 0; m_reset();
    #1;
    n_checks++;
    if ({alarm, fail_count, is_locked} !== 5'b0) begin n_fail++; $display("FAIL async_reset got=%b want=%b", {alarm, fail_count, is_locked}, 5'b0); end
    @(negedge clock); reset = 1;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (dut_vec !== exp_vec() || enter !== 1'b1) begin n_fail++; $display("FAIL async_release_enter got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 2) != 0, 4'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random c=%0d got=%h want=%h", c, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_program_lock();
    test_unlock();
    test_boundaries();
    test_lockout();
    test_clear_reprogram();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Control FSM for the keypad combination lock. Sits between the debounced keypad/button front end and the eight-digit hex display driver.
- Collects up to four hex key entries and programs or checks the passcode.
- Drives the display's digit inputs (hex1..hex4) and its enter/lock/unlock state pulses.
- Enforces a timed lockout after repeated wrong codes.

Parameters:
- MAX_FAILS, 3: consecutive wrong codes that trigger lockout (1..7).
- LOCKOUT_CYCLES, 100000000: lockout duration in clock cycles (1 s at 100 MHz).
- CNT_W, 27: width of the lockout counter; must satisfy 2^CNT_W > LOCKOUT_CYCLES.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- key_valid  in  1  single-cycle pulse, key_code is valid
- key_code  in  4  hex key value 0x0..0xF
- enter_btn  in  1  single-cycle pulse, submit entry
- lock_btn  in  1  single-cycle pulse, re-lock when unlocked
- clear_btn  in  1  single-cycle pulse, discard entry; in UNLOCKED also return to INIT
- hex1, hex2, hex3, hex4  out  4 each  entered digits, hex1 = first entered
- digit_count  out  3  digits entered, 0..4
- enter  out  1  one-cycle pulse, display shows "initial"
- lock  out  1  one-cycle pulse, display shows "locked"
- unlock  out  1  one-cycle pulse, display shows "unlocked"
- is_locked  out  1  high in LOCKED and LOCKOUT
- alarm  out  1  high throughout LOCKOUT
- fail_count  out  3  consecutive failures

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset state (reset low):
  - state INIT; stored code 0x0000.
  - hex1..hex4 = 0; digit_count = 0.
  - enter/lock/unlock = 0; is_locked = 0; alarm = 0; fail_count = 0; lockout counter = 0.
- First cycle after reset release: pulse enter for one cycle so the display shows "I".
- All outputs are registered. Pulses are exactly one cycle wide and occur the cycle after the triggering input.
- Entry buffer (INIT, LOCKED, UNLOCKED only):
  - When key_valid and digit_count < 4: write key_code into hex[digit_count+1] and increment digit_count.
  - Keys arriving with digit_count = 4 are ignored.
  - clear_btn zeroes hex1..hex4 and digit_count.
- Input priority in a single cycle: clear_btn > enter_btn > lock_btn > key_valid. A lower-priority input arriving in the same cycle is dropped.
- enter_btn with digit_count < 4 is ignored, with no state or counter change.
- Code value: code = {hex1, hex2, hex3, hex4}. After any accepted enter, the buffer is cleared on the same clock edge as the transition.
- INIT:
  - enter_btn with 4 digits: store code, pulse lock, go to LOCKED, fail_count = 0.
  - lock_btn is ignored.
- LOCKED, enter_btn with 4 digits:
  - Code matches: pulse unlock, go to UNLOCKED, fail_count = 0.
  - Mismatch: fail_count++. If the new value equals MAX_FAILS, go to LOCKOUT, load counter = LOCKOUT_CYCLES-1, alarm = 1.
  - lock_btn is ignored in LOCKED.
- UNLOCKED:
  - lock_btn: pulse lock, go to LOCKED (stored code kept).
  - clear_btn: clear buffer, pulse enter, go to INIT (stored code kept until a new one is programmed).
  - enter_btn with 4 digits: store new code, pulse lock, go to LOCKED.
- LOCKOUT:
  - All key and button inputs are ignored; buffer held at 0.
  - Counter decrements every cycle. At counter = 0: alarm = 0, fail_count = 0, go to LOCKED. No display pulse is issued (display already shows "L").
- Counter does not wrap. It is only loaded on entering LOCKOUT.
- Reset asserted mid-operation, including mid-lockout: immediate return to the reset state; the stored code is lost.

Test Plan:
- Program and lock: reset, release, keys 1,2,3,4, enter -> enter pulse after release; hex1..4 = 1,2,3,4 with digit_count = 4 before enter; then lock pulse, is_locked = 1, digit_count = 0.
- Correct code: from LOCKED, keys 1,2,3,4, enter -> unlock pulse 1 cycle later, is_locked = 0, fail_count = 0. Then lock_btn -> lock pulse, LOCKED.
- Lockout (MAX_FAILS = 3, LOCKOUT_CYCLES = 20): three wrong codes 0,0,0,0 -> fail_count 1,2; third sets alarm = 1. Keys and enter are ignored for 20 cycles, then alarm = 0, fail_count = 0. Correct code then unlocks.
- Boundaries:
  - Five keys A,B,C,D,E -> hex = A,B,C,D; fifth key dropped.
  - enter after 3 digits -> no state change, digits retained.
  - key_valid and enter_btn in the same cycle with 4 digits -> key dropped, enter processed.
- Clear and reprogram: in UNLOCKED, clear_btn -> enter pulse, INIT. Program 9,8,7,6 -> LOCKED; old code 1,2,3,4 now fails (fail_count = 1) and 9,8,7,6 unlocks.
- Async reset mid-lockout: assert reset during LOCKOUT with no clock edge -> alarm = 0, fail_count = 0, is_locked = 0 immediately; enter pulse after release.
